// File: rtl/la_pkg.sv
// la_pkg: shared FSM encoding and framing constants for the FIFO UART readout (FRAME_HEADER_EN adds a sync byte)
package la_pkg;
    typedef enum logic [2:0] {IDLE, REQ, LATCH, SEND, DONE} state_e;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_CLKS_PER_BIT = 434;
`ifdef FRAME_HEADER_EN
    localparam int HDR_BYTES = 1;
`else
    localparam int HDR_BYTES = 0;
`endif
    localparam int FRAME_BYTES = BYTES_PER_WORD + HDR_BYTES;
endpackage

// File: rtl/fifo_uart_readout_if.sv
// fifo_uart_readout_if: channel FIFO read handshake (empty flag, read data, read strobe)
interface fifo_uart_readout_if;
    logic        fifo_empty;
    logic [31:0] fifo_q;
    logic        fifo_rdreq;
    modport master(input fifo_empty, input fifo_q, output fifo_rdreq);
    modport slave(output fifo_empty, output fifo_q, input fifo_rdreq);
endinterface

// File: rtl/fifo_uart_readout_uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser; done pulses in the last cycle of the stop bit so a new byte can start back-to-back
module uart_tx_byte
    import la_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       _mrst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    logic          active_q, active_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    // bit-period timing, shift-out and end-of-frame detection
    always_comb begin
        tick     = active_q && cnt_q == LAST;
        done     = tick && bit_q == 4'd9;
        tx       = active_q ? shift_q[0] : 1'b1;
        active_d = active_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        if (start && (!active_q || done)) begin
            active_d = 1'b1;
            shift_d  = {1'b1, data, 1'b0};
            bit_d    = '0;
            cnt_d    = '0;
        end else if (tick) begin
            active_d = bit_q != 4'd9;
            shift_d  = shift_q >> 1;
            bit_d    = bit_q + 4'd1;
            cnt_d    = '0;
        end else if (active_q)
            cnt_d = cnt_q + 1'b1;
    end
    // serialiser registers, synchronous active-low reset
    always_ff @(posedge i_clk)
        if (!_mrst) begin
            active_q <= 1'b0;
            shift_q  <= '1;
            bit_q    <= '0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
        end
endmodule

// File: rtl/fifo_uart_readout.sv
// fifo_uart_readout: drains 32-bit FIFO words and sends each LSB-first over UART 8N1 (FRAME_HEADER_EN prepends 0xA5)
module fifo_uart_readout
    import la_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int COUNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  _mrst,
    input  logic                  i_enable,
    fifo_uart_readout_if.master   fifo,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic [COUNT_W-1:0]    o_words_sent
);
    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);
    localparam logic [2:0] HDR      = 3'(HDR_BYTES);
    state_e               state_q, state_d;
    logic                 rdreq_q, rdreq_d;
    logic [31:0]          word_q, word_d;
    logic [2:0]           idx_q, idx_d;
    logic [COUNT_W-1:0]   words_q, words_d;
    logic                 start, done;
    logic [7:0]           data;
    logic [2:0]           nxt;
    // FSM next state, read strobe and byte sequencing; idx counts wire bytes including the header
    always_comb begin
        state_d = state_q;
        rdreq_d = 1'b0;
        word_d  = word_q;
        idx_d   = idx_q;
        words_d = words_q;
        start   = 1'b0;
        nxt     = idx_q + 3'd1 - HDR;
        data    = 8'(word_q >> {nxt, 3'b000});
        case (state_q)
            IDLE: if (i_enable && !fifo.fifo_empty) begin
                state_d = REQ;
                rdreq_d = 1'b1;
            end
            REQ: state_d = LATCH;
            LATCH: begin
                word_d  = fifo.fifo_q;
                idx_d   = '0;
                start   = 1'b1;
                data    = (HDR_BYTES != 0) ? SYNC_BYTE : fifo.fifo_q[7:0];
                state_d = SEND;
            end
            SEND: if (done) begin
                if (idx_q == LAST_IDX)
                    state_d = DONE;
                else begin
                    idx_d = idx_q + 3'd1;
                    start = 1'b1;
                end
            end
            DONE: begin
                words_d = words_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers, synchronous active-low reset
    always_ff @(posedge i_clk)
        if (!_mrst) begin
            state_q <= IDLE;
            rdreq_q <= 1'b0;
            word_q  <= '0;
            idx_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            rdreq_q <= rdreq_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            words_q <= words_d;
        end
    assign fifo.fifo_rdreq = rdreq_q;
    assign o_busy          = state_q != IDLE;
    assign o_words_sent    = words_q;
    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .i_clk(i_clk),
        ._mrst(_mrst),
        .start(start),
        .data(data),
        .tx(o_tx),
        .done(done)
    );
endmodule

// File: tb/tb_fifo_uart_readout.sv
// tb_fifo_uart_readout: FIFO model, UART line decoder and frame model checking the readout end to end
module tb_fifo_uart_readout;
    localparam int CPB = 4;
    localparam int CW  = 2;
`ifdef FRAME_HEADER_EN
    localparam int NB = 5;
    localparam logic [31:0] W1 = 32'hDEADBEEF;
`else
    localparam int NB = 4;
    localparam logic [31:0] W1 = 32'h11223344;
`endif
    localparam int FRAME = 10 * CPB * NB;

    typedef struct {
        logic [31:0]   word;
        logic [CW-1:0] cnt;
    } vec_t;

    logic i_clk = 1'b0, _mrst = 1'b0, i_enable = 1'b0;
    logic o_tx, o_busy;
    logic [CW-1:0] o_words_sent;
    fifo_uart_readout_if fif();

    fifo_uart_readout #(.CLKS_PER_BIT(CPB), .COUNT_W(CW)) dut (
        .i_clk(i_clk),
        ._mrst(_mrst),
        .i_enable(i_enable),
        .fifo(fif),
        .o_tx(o_tx),
        .o_busy(o_busy),
        .o_words_sent(o_words_sent)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    logic [31:0] mem [0:63];
    int wp = 0, rp = 0;
    assign fif.fifo_empty = (wp == rp);
    always @(posedge i_clk)
        if (fif.fifo_rdreq) begin
            fif.fifo_q <= mem[rp[5:0]];
            rp <= rp + 1;
        end

    int rq_t[$];
    int rq_bad = 0;
    logic rq_prev = 1'b0;
    always @(negedge i_clk) begin
        if (fif.fifo_rdreq) rq_t.push_back(cyc);
        if (fif.fifo_rdreq && rq_prev) rq_bad <= rq_bad + 1;
        rq_prev <= fif.fifo_rdreq;
    end

    int wc_t = 0;
    logic [CW-1:0] wprev;
    always @(negedge i_clk) begin
        if (o_words_sent !== wprev) wc_t <= cyc;
        wprev <= o_words_sent;
    end

    logic [7:0] rx[$];
    int rx_t[$];
    int rx_ferr = 0;
    initial begin
        logic [7:0] b;
        int t0;
        forever begin
            @(negedge i_clk);
            if (_mrst && o_tx == 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge i_clk);
                if (o_tx !== 1'b0) rx_ferr++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge i_clk);
                    b[i] = o_tx;
                end
                repeat (CPB) @(negedge i_clk);
                if (o_tx !== 1'b1) rx_ferr++;
                rx.push_back(b);
                rx_t.push_back(t0);
            end
        end
    end

    int checks = 0, errors = 0, sent = 0;
    logic [7:0] exp_b[$];
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wp[5:0]] = w;
        wp = wp + 1;
    endtask

    task automatic expect_word(input logic [31:0] w);
        if (NB == 5) exp_b.push_back(8'hA5);
        for (int i = 0; i < 4; i++) exp_b.push_back(8'((w >> (8 * i)) & 32'hFF));
        sent++;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int i = 0;
        while (rx.size() < n && i < budget) begin
            @(negedge i_clk);
            i++;
        end
        chk("rx_timeout", 32'(rx.size() >= n), 1);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (o_busy && i < budget) begin
            @(negedge i_clk);
            i++;
        end
        chk("idle_timeout", {31'd0, o_busy}, 0);
        repeat (2) @(negedge i_clk);
    endtask

    task automatic flush();
        rx.delete();
        rx_t.delete();
        rq_t.delete();
        exp_b.delete();
    endtask

    task automatic check_bytes(input string name);
        chk({name, "_nbytes"}, rx.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < rx.size(); i++) chk({name, "_byte"}, rx[i], exp_b[i]);
        chk({name, "_count"}, o_words_sent, sent % 4);
    endtask

    initial begin
        tbl[0] = '{$urandom, 2'd1};
        tbl[1] = '{$urandom, 2'd2};
        tbl[2] = '{$urandom, 2'd3};
        tbl[3] = '{$urandom, 2'd0};
        tbl[4] = '{$urandom, 2'd1};

        repeat (3) @(negedge i_clk);
        chk("rst_tx", o_tx, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_rdreq", fif.fifo_rdreq, 0);
        chk("rst_count", o_words_sent, 0);
        _mrst = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("idle_norq", rq_t.size(), 0);

        push(W1);
        expect_word(W1);
        i_enable = 1'b1;
        wait_rx(NB, FRAME + 50);
        wait_idle(50);
        check_bytes("single");
        chk("single_rq", rq_t.size(), 1);
        if (rq_t.size() == 1 && rx_t.size() == NB) begin
            chk("single_lat", rx_t[0] - rq_t[0], 2);
            chk("single_gap", rx_t[NB-1] - rx_t[0], (NB - 1) * 10 * CPB);
            chk("single_len", wc_t - rx_t[0], FRAME + 1);
        end
        flush();

        for (int i = 0; i < 3; i++) begin
            logic [31:0] w;
            w = $urandom;
            push(w);
            expect_word(w);
        end
        wait_rx(3 * NB, 3 * FRAME + 100);
        wait_idle(50);
        check_bytes("b2b");
        chk("b2b_rq", rq_t.size(), 3);
        if (rq_t.size() == 3) begin
            chk("b2b_space0", rq_t[1] - rq_t[0], FRAME + 4);
            chk("b2b_space1", rq_t[2] - rq_t[1], FRAME + 4);
        end
        chk("b2b_empty", fif.fifo_empty, 1);
        flush();

        i_enable = 1'b0;
        begin
            logic [31:0] w0, w1;
            w0 = $urandom;
            w1 = $urandom;
            push(w0);
            push(w1);
            expect_word(w0);
            @(negedge i_clk);
            i_enable = 1'b1;
            wait_rx(NB - 3, FRAME);
            repeat (3 * CPB) @(negedge i_clk);
            i_enable = 1'b0;
            wait_rx(NB, FRAME);
            wait_idle(50);
            repeat (20) @(negedge i_clk);
            check_bytes("drop");
            chk("drop_rq", rq_t.size(), 1);
            chk("drop_notempty", fif.fifo_empty, 0);
            flush();
            expect_word(w1);
            i_enable = 1'b1;
            wait_rx(NB, FRAME + 50);
            wait_idle(50);
            check_bytes("resume");
            chk("resume_empty", fif.fifo_empty, 1);
            flush();
        end

        push($urandom);
        wait_rx(2, FRAME);
        chk("pre_rst_busy", o_busy, 1);
        _mrst = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            chk("mrst_tx", o_tx, 1);
            chk("mrst_busy", o_busy, 0);
            chk("mrst_rdreq", fif.fifo_rdreq, 0);
            chk("mrst_count", o_words_sent, 0);
        end
        _mrst = 1'b1;
        sent = 0;
        repeat (60) begin
            @(negedge i_clk);
            if (o_tx !== 1'b1) chk("post_rst_tx", o_tx, 1);
        end
        flush();
        rx_ferr = 0;

        for (int i = 0; i < 5; i++) begin
            push(tbl[i].word);
            expect_word(tbl[i].word);
            wait_rx(NB, FRAME + 50);
            wait_idle(50);
            check_bytes("wrap");
            chk("wrap_tbl", o_words_sent, tbl[i].cnt);
            flush();
        end

        chk("frame_err", rx_ferr, 0);
        chk("rq_width", rq_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_uart_readout.md
# fifo_uart_readout

Drains captured 32-bit sample words from the channel FIFO and transmits them over a UART 8N1 line to the host, replacing the debounced manual read button. Sits directly downstream of the channel FIFO: it issues read requests, latches the FIFO output, and serialises each word as four bytes, least-significant byte first. It runs on the analyzer clock and shares the system reset line.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2
- COUNT_W, 16, width of the transmitted-word counter

Ports:
- i_clk  input  1  system clock, all logic on rising edge
- _mrst  input  1  reset, synchronous, active-low
- i_enable  input  1  level; 1 = drain FIFO while non-empty
- fifo_empty  input  1  channel FIFO empty flag
- fifo_q  input  32  channel FIFO read data (normal mode, valid the cycle after rdreq)
- fifo_rdreq  output  1  registered read strobe, one cycle per word
- o_tx  output  1  UART transmit line, idle high
- o_busy  output  1  word transfer in progress
- o_words_sent  output  COUNT_W  words fully transmitted since reset

## Operation
- Reset (_mrst=0 sampled on edge): state IDLE, o_tx=1, fifo_rdreq=0, o_busy=0, o_words_sent=0, shift and bit counters cleared. Reset mid-frame truncates the frame; o_tx is 1 from the next cycle.
- States: IDLE, REQ, LATCH, SEND, DONE.
- IDLE: if i_enable & ~fifo_empty → REQ; else stay.
- REQ: fifo_rdreq=1 for exactly this cycle; → LATCH.
- LATCH: capture fifo_q into 32-bit word register; byte index=0; → SEND.
- SEND: transmit byte word[8*idx+7:8*idx] as start(0), d0..d7, stop(1), each bit CLKS_PER_BIT cycles. After stop bit of idx=3 → DONE; else idx+1, next start bit immediately (no idle gap).
- DONE: o_words_sent += 1 (wraps 2^COUNT_W−1 → 0); → IDLE.
- o_busy=1 in REQ, LATCH, SEND, DONE; 0 in IDLE.
- i_enable falling mid-word: current word completes; no new REQ.
- fifo_empty is never consulted after REQ; the read is committed once strobed.
- The FIFO output is sampled only in LATCH; later changes to fifo_q do not affect the byte stream.

## Timing
- Edge k samples i_enable=1, fifo_empty=0 in IDLE → fifo_rdreq high cycle k+1 → word latched at edge ending cycle k+2 → o_tx start bit low from cycle k+3.
- Word on the wire: 4×10×CLKS_PER_BIT cycles (header build: 5×10×CLKS_PER_BIT).
- DONE lasts 1 cycle and IDLE at least 1 cycle, so the minimum spacing between consecutive fifo_rdreq pulses is the frame length + 4 cycles.
- Bit timing counter width: $clog2(CLKS_PER_BIT); it reloads at every bit boundary with zero slip.

## Configuration
- FRAME_HEADER_EN defined: each word is preceded by sync byte 0xA5, sent as byte index −1 with identical framing. The frame is 5 bytes.
- Undefined: 4-byte frame exactly as above. Counter and handshake are identical in both builds.

## Structure
- Shared package la_pkg: state encoding constants, SYNC_BYTE=8'hA5, BYTES_PER_WORD=4, default CLKS_PER_BIT.
- One sub-module, uart_tx_byte: inputs start, data[7:0]; outputs tx, done (1-cycle pulse at end of stop bit). It is parameterised by CLKS_PER_BIT. The parent FSM sequences bytes and handles the FIFO handshake.

## Test plan
- Reset: hold _mrst=0 three cycles mid-SEND → o_tx=1, o_busy=0, fifo_rdreq=0, o_words_sent=0 from the next cycle.
- Single word: CLKS_PER_BIT=4, FIFO holds 32'h11223344, i_enable=1 → one rdreq pulse; decoded bytes 44,33,22,11; o_words_sent=1 after 160 cycles of o_tx activity.
- Back-to-back: FIFO holds 3 words → 3 rdreq pulses, each spaced 164 cycles apart; 12 bytes in order; o_words_sent=3; FIFO ends empty.
- Enable drop: deassert i_enable during byte 1 of word 0 with 2 words queued → word 0 completes; no further rdreq; o_words_sent=1.
- Wrap: COUNT_W=2, send 5 words → o_words_sent sequence 1,2,3,0,1.
- FRAME_HEADER_EN build: word 32'hDEADBEEF → bytes A5,EF,BE,AD,DE; 200 cycles per frame at CLKS_PER_BIT=4.
